// File: rtl/unary_acc_pkg.sv
// unary_acc_pkg: shared state encoding and bitstream-period constants for the unary-rate PE array
package unary_acc_pkg;
  typedef enum logic [1:0] {IDLE, CLR, RUN, DONE} state_t;
  localparam int BITW = 8;
  function automatic int bs_len_of(input int bitw);
    return 1 << bitw;
  endfunction
  localparam int BS_LEN = bs_len_of(BITW);
endpackage

// File: rtl/unary_wrap_cnt.sv
// unary_wrap_cnt: enabled counter with programmable terminal value and wrap pulse
module unary_wrap_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_last,
  output logic [W-1:0] o_cnt,
  output logic         o_wrap
);
  logic [W-1:0] r_cnt;
  assign o_cnt  = r_cnt;
  assign o_wrap = i_en && (r_cnt == i_last);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_cnt <= '0;
    else if (i_clr || o_wrap) r_cnt <= '0;
    else if (i_en) r_cnt <= r_cnt + 1'b1;
  end
endmodule

// File: rtl/unary_acc_ctrl.sv
// unary_acc_ctrl: per-tile clear/run/done sequencer for a row of unary-rate accumulators.
// Define UNARY_ACC_CTRL_EARLY_TERM_EN to make the bitstream period programmable via bs_len_i.
module unary_acc_ctrl
  import unary_acc_pkg::*;
#(
  parameter int BITW = 8,
  parameter int KW   = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [KW-1:0]   k_len_i,
  input  logic            stall_i,
`ifdef UNARY_ACC_CTRL_EARLY_TERM_EN
  input  logic [BITW:0]   bs_len_i,
`endif
  output logic            en_o,
  output logic            clr_o,
  output logic            acc_o,
  output logic            busy_o,
  output logic            out_valid_o,
  input  logic            out_ready_i
);
  localparam logic [BITW-1:0] BS_LAST = BITW'(bs_len_of(BITW) - 1);
  state_t          r_state, w_next;
  logic [KW-1:0]   r_k, w_elem;
  logic [BITW-1:0] w_bit, w_bs_last;
  logic            w_step, w_bit_wrap, w_elem_wrap, w_load;
`ifdef UNARY_ACC_CTRL_EARLY_TERM_EN
  logic [BITW-1:0] r_bs_last;
  // 0 and 2**BITW both truncate to a terminal count of 2**BITW-1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_bs_last <= BS_LAST;
    else if (w_load) r_bs_last <= BITW'(bs_len_i - (BITW+1)'(1));
  end
  assign w_bs_last = r_bs_last;
`else
  assign w_bs_last = BS_LAST;
`endif
  unary_wrap_cnt #(.W(BITW)) u_bit_cnt (
    .clk(clk), .rst_n(rst_n), .i_clr(clr_o), .i_en(w_step),
    .i_last(w_bs_last), .o_cnt(w_bit), .o_wrap(w_bit_wrap)
  );
  unary_wrap_cnt #(.W(KW)) u_elem_cnt (
    .clk(clk), .rst_n(rst_n), .i_clr(clr_o), .i_en(w_bit_wrap),
    .i_last(r_k - 1'b1), .o_cnt(w_elem), .o_wrap(w_elem_wrap)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_k     <= '0;
    end else begin
      r_state <= w_next;
      if (w_load) r_k <= k_len_i;
    end
  end
  always_comb begin
    w_next      = r_state;
    w_step      = (r_state == RUN) && !stall_i;
    en_o        = w_step;
    acc_o       = w_step && (w_bit == '0) && (w_elem == '0);
    clr_o       = r_state == CLR;
    busy_o      = r_state != IDLE;
    out_valid_o = r_state == DONE;
    w_load      = start_i && ((r_state == IDLE) || ((r_state == DONE) && out_ready_i));
    case (r_state)
      IDLE:    w_next = start_i ? CLR : IDLE;
      CLR:     w_next = (r_k == '0) ? DONE : RUN;
      RUN:     w_next = w_elem_wrap ? DONE : RUN;
      DONE:    w_next = out_ready_i ? (start_i ? CLR : IDLE) : DONE;
      default: w_next = IDLE;
    endcase
  end
endmodule

// File: tb/tb_unary_acc_ctrl.sv
// tb_unary_acc_ctrl: table, directed and random tile checks against a per-tile timing model
module tb_unary_acc_ctrl;
  localparam int BITW = 8;
  localparam int KW   = 16;
  logic clk = 0, rst_n = 0, start_i = 0, stall_i = 0, out_ready_i = 0;
  logic [KW-1:0] k_len_i = '0;
  logic en_o, clr_o, acc_o, busy_o, out_valid_o;
`ifdef UNARY_ACC_CTRL_EARLY_TERM_EN
  logic [BITW:0] bs_len_i = '0;
`endif
  int bs_eff = 256;
  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  unary_acc_ctrl #(.BITW(BITW), .KW(KW)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .k_len_i(k_len_i), .stall_i(stall_i),
`ifdef UNARY_ACC_CTRL_EARLY_TERM_EN
    .bs_len_i(bs_len_i),
`endif
    .en_o(en_o), .clr_o(clr_o), .acc_o(acc_o), .busy_o(busy_o),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i)
  );

  typedef struct {int k; int exp_en; int exp_lat;} vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic launch(input int k);
    @(negedge clk);
    start_i = 1;
    k_len_i = KW'(k);
  endtask

  // Stall windows are in cycles after start; start/k_len are scrambled to prove they are ignored.
  task automatic watch(input int pct, input int s0, input int n0, input int s1, input int n1,
                       output int en_c, output int acc_c, output int clr_c, output int lat,
                       output int st, output int bad);
    int cyc;
    bit done;
    cyc = 0; done = 0; en_c = 0; acc_c = 0; clr_c = 0; st = 0; bad = 0; lat = -1;
    while (!done && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      out_ready_i = 0;
      start_i = 1'($urandom_range(1));
      k_len_i = KW'($urandom);
      stall_i = (cyc >= s0 && cyc < s0 + n0) || (cyc >= s1 && cyc < s1 + n1) ||
                ($urandom_range(99) < pct);
      #1;
      if (out_valid_o) begin
        done = 1;
        lat = cyc;
        if (en_o || acc_o || clr_o) bad++;
      end else begin
        if (!busy_o) bad++;
        if (clr_o) clr_c++;
        if (busy_o && !clr_o && stall_i) st++;
        if (acc_o && (en_c != 0 || !en_o)) bad++;
        if (acc_o) acc_c++;
        if (en_o) en_c++;
      end
    end
    start_i = 0;
    stall_i = 0;
  endtask

  task automatic check_tile(input string tag, input int k, input int exp_en, input int exp_lat,
                            input int en_c, input int acc_c, input int clr_c, input int lat,
                            input int bad);
    chk({tag, " en cycles"}, en_c, exp_en);
    chk({tag, " acc pulses"}, acc_c, (k > 0) ? 1 : 0);
    chk({tag, " clr pulses"}, clr_c, 1);
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " protocol errors"}, bad, 0);
  endtask

  task automatic handshake(input int rdly, input string tag);
    int held;
    held = 0;
    repeat (rdly) begin
      @(negedge clk);
      #1;
      if (out_valid_o && busy_o && !en_o) held++;
    end
    chk({tag, " valid held"}, held, rdly);
    @(negedge clk);
    out_ready_i = 1;
    @(negedge clk);
    out_ready_i = 0;
    #1;
    chk({tag, " idle after handshake"}, int'({busy_o, out_valid_o}), 0);
  endtask

  initial begin
    vec_t tbl[4];
    int en_c, acc_c, clr_c, lat, st, bad, k;
    tbl[0] = '{3, 768, 770};
    tbl[1] = '{0, 0, 2};
    tbl[2] = '{1, 256, 258};
    tbl[3] = '{2, 512, 514};
    #1;
    chk("reset outputs", int'({en_o, clr_o, acc_o, busy_o, out_valid_o}), 0);
    #12 rst_n = 1;

    foreach (tbl[i]) begin
      launch(tbl[i].k);
      watch(0, 0, 0, 0, 0, en_c, acc_c, clr_c, lat, st, bad);
      check_tile($sformatf("vec%0d", i), tbl[i].k, tbl[i].exp_en, tbl[i].exp_lat,
                 en_c, acc_c, clr_c, lat, bad);
      handshake(i, $sformatf("vec%0d", i));
    end

    launch(2);
    watch(0, 2, 1, 100, 10, en_c, acc_c, clr_c, lat, st, bad);
    chk("stall count", st, 11);
    check_tile("stall", 2, 512, 2 + 512 + 11, en_c, acc_c, clr_c, lat, bad);
    handshake(1, "stall");

    launch(1);
    watch(0, 0, 0, 0, 0, en_c, acc_c, clr_c, lat, st, bad);
    check_tile("b2b first", 1, 256, 258, en_c, acc_c, clr_c, lat, bad);
    st = 0;
    repeat (20) begin
      @(negedge clk);
      #1;
      if (out_valid_o) st++;
    end
    chk("b2b valid held", st, 20);
    @(negedge clk);
    out_ready_i = 1;
    start_i = 1;
    k_len_i = 1;
    watch(0, 0, 0, 0, 0, en_c, acc_c, clr_c, lat, st, bad);
    check_tile("b2b second", 1, 256, 258, en_c, acc_c, clr_c, lat, bad);
    handshake(0, "b2b");

    launch(3);
    @(negedge clk);
    start_i = 0;
    repeat (357) @(negedge clk);
    #1;
    chk("mid-run en", int'(en_o), 1);
    rst_n = 0;
    #1;
    chk("async reset outputs", int'({en_o, clr_o, acc_o, busy_o, out_valid_o}), 0);
    @(negedge clk);
    rst_n = 1;
    launch(2);
    watch(0, 0, 0, 0, 0, en_c, acc_c, clr_c, lat, st, bad);
    check_tile("post reset", 2, 512, 514, en_c, acc_c, clr_c, lat, bad);
    handshake(2, "post reset");

`ifdef UNARY_ACC_CTRL_EARLY_TERM_EN
    bs_len_i = 16;
    bs_eff = 16;
    launch(4);
    watch(0, 0, 0, 0, 0, en_c, acc_c, clr_c, lat, st, bad);
    check_tile("early16", 4, 64, 66, en_c, acc_c, clr_c, lat, bad);
    handshake(1, "early16");
    bs_len_i = 0;
    bs_eff = 256;
    launch(1);
    watch(0, 0, 0, 0, 0, en_c, acc_c, clr_c, lat, st, bad);
    check_tile("early0", 1, 256, 258, en_c, acc_c, clr_c, lat, bad);
    handshake(1, "early0");
`endif

    for (int t = 0; t < 6; t++) begin
      k = $urandom_range(3);
      launch(k);
      watch($urandom_range(30), 0, 0, 0, 0, en_c, acc_c, clr_c, lat, st, bad);
      check_tile($sformatf("rand%0d", t), k, k * bs_eff, 2 + k * bs_eff + st,
                 en_c, acc_c, clr_c, lat, bad);
      handshake($urandom_range(5), $sformatf("rand%0d", t));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
